// File: rtl/sensor_snapshot_regs.sv
// Sensor register bank: live capture, atomic shadow snapshot,
// per-channel staleness and a byte-wide burst read port.
module sensor_snapshot_regs #(
  parameter int NUM_CH      = 16,
  parameter int CH_BYTES    = 2,
  parameter int ADDR_W      = 8,
  parameter int STALE_LIMIT = 250
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic                         snap_req,
  output logic                         snap_ack,
  output logic [7:0]                   snap_seq,
  input  logic                         rd_start,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_next,
  input  logic                         rd_stop,
  output logic                         burst_active,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid
);

  localparam int CW       = CH_BYTES * 8;
  localparam int NB       = NUM_CH * CH_BYTES;
  localparam int SB       = (NUM_CH + 7) / 8;
  localparam int MAP_SIZE = 1 + NB + SB;
  localparam int AGE_W    = $clog2(STALE_LIMIT + 1);
  localparam logic [AGE_W-1:0] LIM_A = AGE_W'(STALE_LIMIT);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0][CW-1:0]    live_q, live_d;
  logic [NUM_CH-1:0][CW-1:0]    shadow_q, shadow_d;
  logic [NUM_CH-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_CH-1:0]            stale_d;
  logic [NUM_CH-1:0]            shst_q, shst_d;
  logic [7:0]                   seq_q, seq_d;
  logic                         snap_ack_q, snap_ack_d;
  logic                         burst_q, burst_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic [7:0]                   rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;

  logic                         do_copy;
  logic                         rd_fire;
  logic [ADDR_W-1:0]            raddr;
  logic [NUM_CH-1:0][CW-1:0]    src_sh;
  logic [SB*8-1:0]              stale_pad;
  logic [7:0]                   src_seq;
  logic [7:0]                   rd_byte;

  always_comb begin : capture
    for (int c = 0; c < NUM_CH; c++) begin
      live_d[c] = live_q[c];
      age_d[c]  = age_q[c];
      if (ch_valid[c]) begin
        live_d[c] = ch_data[c*CW +: CW];
        age_d[c]  = '0;
      end else if (age_q[c] != LIM_A) begin
        age_d[c] = age_q[c] + AGE_W'(1);
      end
      stale_d[c] = (age_d[c] == LIM_A);
    end
  end

  always_comb begin : snap_fsm
    state_d = state_q;
    do_copy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          if (!burst_q || rd_stop) do_copy = 1'b1;
          else state_d = PENDING;
        end
      end
      PENDING: begin
        if (rd_stop) begin
          do_copy = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    shadow_d   = do_copy ? live_d : shadow_q;
    shst_d     = do_copy ? stale_d : shst_q;
    seq_d      = do_copy ? seq_q + 8'd1 : seq_q;
    snap_ack_d = do_copy;
  end

  // A starting burst sees a same-edge copy; an ongoing one never does.
  always_comb begin : rd_mux
    src_sh    = rd_start ? shadow_d : shadow_q;
    src_seq   = rd_start ? seq_d : seq_q;
    stale_pad = '0;
    stale_pad[NUM_CH-1:0] = rd_start ? shst_d : shst_q;
    raddr   = rd_start ? rd_addr : ptr_q;
    rd_byte = '0;
    if (raddr == '0) rd_byte = src_seq;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < CH_BYTES; b++) begin
        if (raddr == ADDR_W'(1 + c*CH_BYTES + b))
          rd_byte = src_sh[c][(CH_BYTES-1-b)*8 +: 8];
      end
    end
    for (int k = 0; k < SB; k++) begin
      if (raddr == ADDR_W'(1 + NB + k))
        rd_byte = stale_pad[k*8 +: 8];
    end
  end

  always_comb begin : rd_ctl
    rd_fire    = rd_start | (rd_next & burst_q);
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_byte : rd_data_q;
    ptr_d      = ptr_q;
    if (rd_fire) begin
      if (raddr == ADDR_W'(MAP_SIZE - 1)) ptr_d = '0;
      else ptr_d = raddr + ADDR_W'(1);
    end
    burst_d = burst_q;
    unique case (1'b1)
      rd_start: burst_d = 1'b1;
      rd_stop:  burst_d = 1'b0;
      default:  burst_d = burst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      live_q     <= '0;
      shadow_q   <= '0;
      age_q      <= {NUM_CH{LIM_A}};
      shst_q     <= '1;
      seq_q      <= '0;
      snap_ack_q <= 1'b0;
      burst_q    <= 1'b0;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      age_q      <= age_d;
      shst_q     <= shst_d;
      seq_q      <= seq_d;
      snap_ack_q <= snap_ack_d;
      burst_q    <= burst_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign snap_ack     = snap_ack_q;
  assign snap_seq     = seq_q;
  assign burst_active = burst_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule
